// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder bit per clock, LSB first.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, FINISH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sum_bit, carry_nx, last;

    assign sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last     = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ADD;
                a_d     = A;
                b_d     = B;
                s_d     = '0;
                carry_d = Cin;
                cout_d  = 1'b0;
                cnt_d   = '0;
            end
            ADD: begin
                // sum bits enter at the MSB so the result is LSB-aligned after WIDTH shifts
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                s_d     = {sum_bit, s_q[WIDTH-1:1]};
                carry_d = carry_nx;
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? FINISH : ADD;
                cout_d  = last ? carry_nx : cout_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == FINISH;
    assign S    = s_q;
    assign Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table plus corner sequences for the serial adder, WIDTH=8 and WIDTH=2.
module tb_serial_adder;
    logic       clk = 1'b0, rst = 1'b1;
    logic       start = 1'b0, Cin = 1'b0, busy, done, Cout;
    logic [7:0] A = '0, B = '0, S;
    logic       st2 = 1'b0, c2 = 1'b0, busy2, done2, cout2;
    logic [1:0] a2 = '0, b2 = '0, s2;

    int n_total = 0, n_pass = 0;

    typedef struct {logic [7:0] a, b; logic cin; logic [7:0] s; logic cout;} vec_t;
    typedef struct {logic [7:0] s; logic c;} exp_t;
    vec_t tbl[8];
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .S(S), .Cout(Cout)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .A(a2), .B(b2), .Cin(c2),
        .busy(busy2), .done(done2), .S(s2), .Cout(cout2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // edges counted with the accepting edge as edge 1, so done appears after edge WIDTH+1
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c);
        int edges, busy_n;
        bit seen;
        logic [8:0] sum;
        exp_t e;
        sum = a + b + c;
        A = a; B = b; Cin = c; start = 1'b1;
        sb.push_back('{s: sum[7:0], c: sum[8]});
        tick();
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_clear_s", S, 0);
        chk("accept_clear_cout", Cout, 0);
        edges = 1; busy_n = 1; seen = 0;
        while (!seen && edges < 20) begin
            tick();
            edges++;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
        chk("latency_edges", edges, 9);
        chk("busy_cycles", busy_n, 9);
        chk("sb_size", sb.size(), 1);
        e = sb.pop_front();
        chk("sum", S, e.s);
        chk("cout", Cout, e.c);
        tick();
        chk("done_width", done, 0);
        chk("idle_busy", busy, 0);
        chk("hold_s", S, e.s);
        chk("hold_cout", Cout, e.c);
    endtask

    initial begin
        int n, prev, found;
        bit last_done;
        logic [2:0] ref2;
        tbl[0] = '{8'd3,   8'd5,   1'b0, 8'd8,   1'b0};
        tbl[1] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1};
        tbl[2] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
        tbl[3] = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
        tbl[4] = '{8'h55,  8'hAA,  1'b1, 8'h00,  1'b1};
        tbl[5] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1};
        tbl[6] = '{8'd100, 8'd27,  1'b1, 8'd128, 1'b0};
        tbl[7] = '{8'h0F,  8'hF1,  1'b0, 8'h00,  1'b1};

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", S, 0);
        chk("rst_cout", Cout, 0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [8:0] tsum;
            tsum = tbl[i].a + tbl[i].b + tbl[i].cin;
            chk("table_self", {tsum[8], tsum[7:0]}, {tbl[i].cout, tbl[i].s});
            run_add(tbl[i].a, tbl[i].b, tbl[i].cin);
            chk("table_s", S, tbl[i].s);
            chk("table_cout", Cout, tbl[i].cout);
        end

        for (int i = 0; i < 6; i++)
            run_add(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // start with new operands during the 3rd ADD cycle must be ignored
        A = 8'd3; B = 8'd5; Cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        A = 8'd7; B = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; found = -1;
        for (int e = 5; e <= 25; e++) begin
            tick();
            if (done) begin
                n++;
                if (found < 0) found = e;
                chk("ignore_s", S, 8);
                chk("ignore_cout", Cout, 0);
            end
        end
        chk("ignore_pulses", n, 1);
        chk("ignore_edge", found, 9);

        // reset during the 4th ADD cycle aborts with no done
        A = 8'd255; B = 8'd255; Cin = 1'b1; start = 1'b1;
        sb.push_back('{s: 8'd255, c: 1'b1});
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_add_s", S, 8'hE0);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_s", S, 0);
        chk("arst_cout", Cout, 0);
        chk("arst_done", done, 0);
        void'(sb.pop_front());
        #1 rst = 1'b0;
        n = 0;
        for (int e = 0; e < 15; e++) begin
            tick();
            if (done) n++;
        end
        chk("abort_no_done", n, 0);
        run_add(8'd1, 8'd1, 1'b1);
        chk("post_rst_s", S, 3);
        chk("post_rst_cout", Cout, 0);

        // start held high: results every WIDTH+2 cycles, one-cycle done
        A = 8'd10; B = 8'd20; Cin = 1'b0; start = 1'b1;
        n = 0; prev = -1; last_done = 0;
        for (int e = 0; e < 45; e++) begin
            tick();
            if (done) begin
                n++;
                chk("held_s", S, 30);
                if (prev >= 0) chk("held_spacing", e - prev, 10);
                if (last_done) chk("held_width", 2, 1);
                prev = e;
            end
            last_done = done;
        end
        chk("held_pulses", n >= 4, 1);
        start = 1'b0;
        for (int e = 0; e < 12; e++) tick();
        chk("held_idle", busy, 0);

        // exhaustive WIDTH=2
        for (int i = 0; i < 32; i++) begin
            a2 = 2'(i >> 3); b2 = 2'(i >> 1); c2 = 1'(i);
            ref2 = a2 + b2 + c2;
            st2 = 1'b1;
            tick();
            st2 = 1'b0;
            found = 0;
            for (int e = 0; e < 10 && found == 0; e++) begin
                tick();
                if (done2) found = 1;
            end
            chk("w2_done", found, 1);
            chk("w2_sum", {cout2, s2}, ref2);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
